// File: rtl/axilite_ip_arbiter.sv
// rtl/axilite_ip_arbiter.sv - round-robin arbiter sharing one IP register port between N_REQ requesters
module axilite_ip_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                          aclk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_vld,
   output logic [N_REQ-1:0]              req_rdy,
   input  logic [N_REQ-1:0]              req_wen,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [N_REQ-1:0]              rsp_vld,
   output logic                          rsp_err,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          ip_en,
   output logic                          ip_wen,
   output logic [ADDR_WIDTH-1:0]         ip_addr,
   output logic [DATA_WIDTH-1:0]         ip_wdata,
   input  logic                          ip_rack,
   input  logic [DATA_WIDTH-1:0]         ip_rdata
);
   localparam int PW = $clog2(N_REQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;
   localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          owner_q, owner_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   ip_en_q, ip_en_d;
   logic                   ip_wen_q, ip_wen_d;
   logic [ADDR_WIDTH-1:0]  ip_addr_q, ip_addr_d;
   logic [DATA_WIDTH-1:0]  ip_wdata_q, ip_wdata_d;
   logic [N_REQ-1:0]       rsp_vld_q, rsp_vld_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

   logic                   hi_hit, lo_hit, grant_vld, sel_wen;
   logic [PW-1:0]          g_hi, g_lo, grant;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;

   // g_hi: first requester at or above the pointer; g_lo: first overall (the wrapped choice)
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      g_hi   = '0;
      g_lo   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_vld[i]) begin
            g_lo   = PW'(i);
            lo_hit = 1'b1;
            if (PW'(i) >= ptr_q) begin
               g_hi   = PW'(i);
               hi_hit = 1'b1;
            end
         end
      end
      grant     = hi_hit ? g_hi : g_lo;
      grant_vld = lo_hit && (state_q == IDLE);
      sel_wen   = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      req_rdy   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (PW'(i) == grant) begin
            sel_wen    = req_wen[i];
            sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            req_rdy[i] = grant_vld;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      ip_en_d    = 1'b0;
      ip_wen_d   = ip_wen_q;
      ip_addr_d  = ip_addr_q;
      ip_wdata_d = ip_wdata_q;
      rsp_vld_d  = '0;
      rsp_err_d  = 1'b0;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               ip_en_d    = 1'b1;
               ip_wen_d   = sel_wen;
               ip_addr_d  = sel_addr;
               ip_wdata_d = sel_wdata;
               ptr_d      = (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
               if (!sel_wen) begin
                  state_d = RD_WAIT;
                  owner_d = grant;
                  cnt_d   = '0;
               end
            end
         end
         RD_WAIT: begin
            // an acknowledge in the expiry cycle still completes normally
            if (ip_rack) begin
               rsp_vld_d  = REQ_ONE << owner_q;
               rsp_data_d = ip_rdata;
               state_d    = IDLE;
            end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
               rsp_vld_d  = REQ_ONE << owner_q;
               rsp_err_d  = 1'b1;
               rsp_data_d = '0;
               state_d    = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         ip_en_q    <= 1'b0;
         ip_wen_q   <= 1'b0;
         ip_addr_q  <= '0;
         ip_wdata_q <= '0;
         rsp_vld_q  <= '0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         ip_en_q    <= ip_en_d;
         ip_wen_q   <= ip_wen_d;
         ip_addr_q  <= ip_addr_d;
         ip_wdata_q <= ip_wdata_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_err_q  <= rsp_err_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign ip_en    = ip_en_q;
   assign ip_wen   = ip_wen_q;
   assign ip_addr  = ip_addr_q;
   assign ip_wdata = ip_wdata_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_err  = rsp_err_q;
   assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_axilite_ip_arbiter.sv
// tb/tb_axilite_ip_arbiter.sv - scoreboard bench for axilite_ip_arbiter
module tb_axilite_ip_arbiter;
   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct { int cyc; logic wen; logic [AW-1:0] addr; logic [DW-1:0] data; } ip_exp_t;
   typedef struct { int cyc; logic [N-1:0] vld; logic err; logic [DW-1:0] data; } rsp_exp_t;

   logic aclk = 1'b0;
   logic rst;
   logic [N-1:0]    req_vld, req_rdy, req_wen, rsp_vld;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic            rsp_err, ip_en, ip_wen, ip_rack;
   logic [DW-1:0]   rsp_data, ip_wdata, ip_rdata;
   logic [AW-1:0]   ip_addr;

   axilite_ip_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .aclk(aclk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .ip_en(ip_en), .ip_wen(ip_wen), .ip_addr(ip_addr), .ip_wdata(ip_wdata),
      .ip_rack(ip_rack), .ip_rdata(ip_rdata)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   bit mon_en = 0;

   ip_exp_t  ip_q[$];
   rsp_exp_t rsp_q[$];
   ip_exp_t  mon_ie;
   rsp_exp_t mon_re;

   // requester-side pending operations
   bit            op_pend[N];
   bit            op_wen[N];
   logic [AW-1:0] op_addr[N];
   logic [DW-1:0] op_data[N];
   int            op_lat[N];
   int            op_lat2[N];

   // reference model state
   bit busy = 0;
   int owner = 0, rd_cyc = 0, ptr = 0;
   int rack_a = -1, rack_b = -1;
   bit stray_en = 0, rand_en = 0, refill = 0, record_g = 0;
   logic [N-1:0] gseq[$];

   // monitor: pops the expected IP access / response whenever the DUT presents one
   always @(negedge aclk) begin
      if (mon_en) begin
         while (ip_q.size() > 0 && ip_q[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL ip_missing cyc=%0d got ip_en=%b required ip_en=1 addr=%h", cyc, ip_en, ip_q[0].addr);
            void'(ip_q.pop_front());
         end
         if (ip_en !== 1'b0) begin
            checks++;
            if (ip_q.size() == 0 || ip_q[0].cyc != cyc) begin
               failures++;
               $display("FAIL ip_unexpected cyc=%0d got ip_en=%b addr=%h required no access", cyc, ip_en, ip_addr);
            end else begin
               mon_ie = ip_q.pop_front();
               if (ip_wen !== mon_ie.wen || ip_addr !== mon_ie.addr || (mon_ie.wen && ip_wdata !== mon_ie.data)) begin
                  failures++;
                  $display("FAIL ip_access cyc=%0d got wen=%b addr=%h data=%h required wen=%b addr=%h data=%h",
                           cyc, ip_wen, ip_addr, ip_wdata, mon_ie.wen, mon_ie.addr, mon_ie.data);
               end
            end
         end
         while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL rsp_missing cyc=%0d got rsp_vld=%b required rsp_vld=%b", cyc, rsp_vld, rsp_q[0].vld);
            void'(rsp_q.pop_front());
         end
         if (rsp_vld !== '0) begin
            checks++;
            if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
               failures++;
               $display("FAIL rsp_unexpected cyc=%0d got rsp_vld=%b required none", cyc, rsp_vld);
            end else begin
               mon_re = rsp_q.pop_front();
               if (rsp_vld !== mon_re.vld || rsp_err !== mon_re.err || rsp_data !== mon_re.data) begin
                  failures++;
                  $display("FAIL rsp cyc=%0d got vld=%b err=%b data=%h required vld=%b err=%b data=%h",
                           cyc, rsp_vld, rsp_err, rsp_data, mon_re.vld, mon_re.err, mon_re.data);
               end
            end
         end
      end
   end

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic post(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int lat, input int lat2);
      op_pend[i] = 1; op_wen[i] = w; op_addr[i] = a; op_data[i] = d;
      op_lat[i] = lat; op_lat2[i] = lat2;
   endtask

   // one clock: drive inputs, let req_rdy settle, advance the model, wait for the next negedge
   task automatic step();
      int m, g;
      bit was_busy;
      logic [N-1:0] vld_vec, exp_rdy;
      m = cyc;
      for (int i = 0; i < N; i++) begin
         vld_vec[i] = op_pend[i];
         req_vld[i] = op_pend[i];
         req_wen[i] = op_wen[i];
         req_addr[i*AW +: AW] = op_addr[i];
         req_wdata[i*DW +: DW] = op_data[i];
      end
      ip_rack  = !rst && (m == rack_a || m == rack_b || (stray_en && $urandom_range(0, 5) == 0));
      ip_rdata = $urandom;
      #1;
      if (rst) begin
         busy = 0; ptr = 0; rack_a = -1; rack_b = -1;
      end else begin
         was_busy = busy;
         if (was_busy && m > rd_cyc) begin
            if (ip_rack) begin
               rsp_q.push_back('{m + 1, N'(1) << owner, 1'b0, ip_rdata});
               busy = 0;
            end else if (m == rd_cyc + TO) begin
               rsp_q.push_back('{m + 1, N'(1) << owner, 1'b1, '0});
               busy = 0;
            end
         end
         g = was_busy ? -1 : pick(vld_vec, ptr);
         exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
         checks++;
         if (req_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL req_rdy cyc=%0d got %b required %b", m, req_rdy, exp_rdy);
         end
         if (record_g) gseq.push_back(req_rdy);
         if (g >= 0) begin
            ip_q.push_back('{m + 1, op_wen[g], op_addr[g], op_data[g]});
            ptr = (g + 1) % N;
            if (!op_wen[g]) begin
               busy = 1; owner = g; rd_cyc = m;
               rack_a = (op_lat[g] > 0) ? m + op_lat[g] : -1;
               rack_b = (op_lat2[g] > 0) ? m + op_lat2[g] : -1;
            end
            op_pend[g] = 0;
            if (refill) post(g, 1, AW'($urandom), $urandom, 0, 0);
         end
         if (rand_en)
            for (int i = 0; i < N; i++)
               if (!op_pend[i] && $urandom_range(0, 2) == 0)
                  post(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom_range(0, TO + 2), 0);
      end
      @(negedge aclk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      rst = 1; req_vld = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
      ip_rack = 0; ip_rdata = '0;
      for (int i = 0; i < N; i++) begin
         op_pend[i] = 0; op_wen[i] = 0; op_addr[i] = '0; op_data[i] = '0; op_lat[i] = 0; op_lat2[i] = 0;
      end
      @(negedge aclk);
      run(3);
      rst = 0;
      checks += 4;
      if (ip_en !== 1'b0)  begin failures++; $display("FAIL reset_ip_en got %b required 0", ip_en); end
      if (rsp_vld !== '0)  begin failures++; $display("FAIL reset_rsp_vld got %b required 0", rsp_vld); end
      if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b required 0", rsp_err); end
      if (req_rdy !== '0)  begin failures++; $display("FAIL reset_req_rdy got %b required 0", req_rdy); end
      mon_en = 1;

      // fairness: everyone writes continuously from pointer 0
      refill = 1; record_g = 1;
      post(0, 1, 8'h01, $urandom, 0, 0);
      post(1, 1, 8'h02, $urandom, 0, 0);
      post(2, 1, 8'h03, $urandom, 0, 0);
      run(6);
      refill = 0; record_g = 0;
      checks++;
      if (gseq.size() != 6) begin
         failures++; $display("FAIL rr_count got %0d grants required 6", gseq.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (gseq[k] !== (N'(1) << (k % N))) begin
               failures++; $display("FAIL rr_grant k=%0d got %b required %b", k, gseq[k], N'(1) << (k % N));
            end
         end
      end
      run(5);

      post(0, 1, 8'h10, 32'hDEADBEEF, 0, 0);          run(3);
      post(1, 0, 8'h04, '0, 3, 0);                     run(8);
      post(1, 0, 8'h20, '0, 3, 0);                     run(1);
      post(0, 1, 8'h30, 32'hCAFEF00D, 0, 0);           run(8);
      post(0, 0, 8'h40, '0, 0, 7);                     run(10);
      post(2, 0, 8'h44, '0, TO, 0);                    run(8);

      // reset two cycles into a read, then a contested grant must start at requester 0
      post(1, 0, 8'h48, '0, 0, 0);                     run(2);
      rst = 1;                                         run(1);
      rst = 0;
      post(2, 1, 8'h50, $urandom, 0, 0);
      post(0, 1, 8'h54, $urandom, 0, 0);               run(5);

      stray_en = 1; rand_en = 1;                       run(3000);
      rand_en = 0;                                     run(40);
      stray_en = 0;                                    run(4);

      checks++;
      if (ip_q.size() != 0 || rsp_q.size() != 0 || op_pend[0] || op_pend[1] || op_pend[2]) begin
         failures++;
         $display("FAIL drain got ip_q=%0d rsp_q=%0d pending=%b%b%b required all empty",
                  ip_q.size(), rsp_q.size(), op_pend[2], op_pend[1], op_pend[0]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
